fractal_sync_cnt_local_rf: RTL and testbench

Counting successor of the 1D local sync register file. It replaces the single toggle bit per ID with a CNT_WIDTH arrival counter and a per-ID waiter mask. Each port carries a weighted arrival, so one port can represent several children aggregated lower in the fractal tree. A barrier releases every participating port once its accumulated weight reaches N_ARRIVALS. It sits at each tree node, between the node's ports and the upward/downward propagation logic.

---
 rtl/fractal_sync_cnt_local_rf.sv | 178 +++++++++++++++++
 tb/tb_fractal_sync_cnt_local_rf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_cnt_local_rf.sv
// Counting local sync register file: per-ID weighted arrival counter plus waiter mask.
// Releases all participants once the accumulated weight reaches N_ARRIVALS.
module fractal_sync_cnt_local_rf #(
  parameter int unsigned N_REGS     = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned N_ARRIVALS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i [N_PORTS],
  input  logic [ID_WIDTH-1:0]  req_id_i    [N_PORTS],
  input  logic [CNT_WIDTH-1:0] req_cnt_i   [N_PORTS],
  output logic                 req_ready_o [N_PORTS],
  output logic                 rsp_valid_o [N_PORTS],
  output logic [ID_WIDTH-1:0]  rsp_id_o    [N_PORTS],
  output logic                 rsp_err_o   [N_PORTS]
);

  if ((1 << ID_WIDTH) < N_REGS) begin : g_chk_id
    $fatal(1, "ID_WIDTH too narrow for N_REGS");
  end
  if (((1 << CNT_WIDTH) - 1) < N_ARRIVALS) begin : g_chk_cnt
    $fatal(1, "CNT_WIDTH too narrow for N_ARRIVALS");
  end
  if (N_ARRIVALS < 1) begin : g_chk_arr
    $fatal(1, "N_ARRIVALS must be at least 1");
  end

  // Wide enough for a full counter plus every port's maximum weight.
  localparam int unsigned SUM_W = CNT_WIDTH + $clog2(N_PORTS) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                 state_q   [N_PORTS];
  state_t                 state_d   [N_PORTS];
  logic [CNT_WIDTH-1:0]   cnt_q     [N_REGS];
  logic [CNT_WIDTH-1:0]   cnt_d     [N_REGS];
  logic [N_PORTS-1:0]     mask_q    [N_REGS];
  logic [N_PORTS-1:0]     mask_d    [N_REGS];
  logic [SUM_W-1:0]       sum       [N_REGS];
  logic [N_PORTS-1:0]     arrive    [N_REGS];
  logic [N_REGS-1:0]      done;
  logic [N_REGS-1:0]      over;
  logic [N_PORTS-1:0]     bad;
  logic [N_PORTS-1:0]     good;
  logic                   rsp_valid_q [N_PORTS];
  logic                   rsp_valid_d [N_PORTS];
  logic [ID_WIDTH-1:0]    rsp_id_q    [N_PORTS];
  logic [ID_WIDTH-1:0]    rsp_id_d    [N_PORTS];
  logic                   rsp_err_q   [N_PORTS];
  logic                   rsp_err_d   [N_PORTS];
  logic                   inv_ok;

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      req_ready_o[p] = (state_q[p] == IDLE);
      rsp_valid_o[p] = rsp_valid_q[p];
      rsp_id_o[p]    = rsp_id_q[p];
      rsp_err_o[p]   = rsp_err_q[p];
    end
  end

  // Classify accepted requests; errors never reach the counters.
  always_comb begin
    bad  = '0;
    good = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (req_valid_i[p] && (state_q[p] == IDLE)) begin
        if ((32'(req_id_i[p]) >= N_REGS) || (req_cnt_i[p] == '0)) begin
          bad[p] = 1'b1;
        end else begin
          good[p] = 1'b1;
        end
      end
    end
  end

  // Same-cycle arrivals on one ID are merged into a single sum.
  always_comb begin
    done = '0;
    over = '0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      sum[k]    = SUM_W'(cnt_q[k]);
      arrive[k] = '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (good[p] && (req_id_i[p] == ID_WIDTH'(k))) begin
          arrive[k][p] = 1'b1;
          sum[k]       = sum[k] + SUM_W'(req_cnt_i[p]);
        end
      end
      done[k] = (sum[k] >= SUM_W'(N_ARRIVALS));
      over[k] = (sum[k] >  SUM_W'(N_ARRIVALS));
      if (done[k]) begin
        cnt_d[k]  = '0;
        mask_d[k] = '0;
      end else begin
        cnt_d[k]  = CNT_WIDTH'(sum[k]);
        mask_d[k] = mask_q[k] | arrive[k];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      state_d[p]     = state_q[p];
      rsp_valid_d[p] = 1'b0;
      rsp_id_d[p]    = rsp_id_q[p];
      rsp_err_d[p]   = 1'b0;
      if (bad[p]) begin
        rsp_valid_d[p] = 1'b1;
        rsp_err_d[p]   = 1'b1;
        rsp_id_d[p]    = req_id_i[p];
      end
      for (int unsigned k = 0; k < N_REGS; k++) begin
        if (done[k] && (mask_q[k][p] || arrive[k][p])) begin
          rsp_valid_d[p] = 1'b1;
          rsp_err_d[p]   = over[k];
          rsp_id_d[p]    = ID_WIDTH'(k);
          state_d[p]     = IDLE;
        end else if (arrive[k][p]) begin
          state_d[p] = WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p]     <= IDLE;
        rsp_valid_q[p] <= 1'b0;
        rsp_id_q[p]    <= '0;
        rsp_err_q[p]   <= 1'b0;
      end
      for (int unsigned k = 0; k < N_REGS; k++) begin
        cnt_q[k]  <= '0;
        mask_q[k] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p]     <= state_d[p];
        rsp_valid_q[p] <= rsp_valid_d[p];
        rsp_id_q[p]    <= rsp_id_d[p];
        rsp_err_q[p]   <= rsp_err_d[p];
      end
      for (int unsigned k = 0; k < N_REGS; k++) begin
        cnt_q[k]  <= cnt_d[k];
        mask_q[k] <= mask_d[k];
      end
    end
  end

  // Structural invariants between masks, port states and counters.
  always_comb begin
    int unsigned hits;
    inv_ok = 1'b1;
    hits   = 0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      hits = 0;
      for (int unsigned k = 0; k < N_REGS; k++) begin
        if (mask_q[k][p]) hits = hits + 1;
      end
      if (hits > 1) inv_ok = 1'b0;
      if ((hits != 0) != (state_q[p] == WAIT)) inv_ok = 1'b0;
    end
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if ((cnt_q[k] == '0) != (mask_q[k] == '0)) inv_ok = 1'b0;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) inv_ok);

endmodule

// File: tb/tb_fractal_sync_cnt_local_rf.sv
// Directed bench for fractal_sync_cnt_local_rf with a response scoreboard
// (N_REGS=3 so that ID 3 is out of range).
module tb_fractal_sync_cnt_local_rf;
  localparam int unsigned NP = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid [NP];
  logic [IW-1:0] req_id    [NP];
  logic [CW-1:0] req_cnt   [NP];
  logic          req_ready [NP];
  logic          rsp_valid [NP];
  logic [IW-1:0] rsp_id    [NP];
  logic          rsp_err   [NP];

  typedef struct {
    int port;
    int id;
    int err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  fractal_sync_cnt_local_rf #(
    .N_REGS    (3),
    .ID_WIDTH  (IW),
    .N_PORTS   (NP),
    .CNT_WIDTH (CW),
    .N_ARRIVALS(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_id_i   (req_id),
    .req_cnt_i  (req_cnt),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_id_o   (rsp_id),
    .rsp_err_o  (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int ready_bits();
    int r = 0;
    for (int i = 0; i < NP; i++) if (req_ready[i]) r |= (1 << i);
    return r;
  endfunction

  function automatic int valid_bits();
    int r = 0;
    for (int i = 0; i < NP; i++) if (rsp_valid[i]) r |= (1 << i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NP; i++) begin
      req_valid[i] = 1'b0;
      req_id[i]    = '0;
      req_cnt[i]   = '0;
    end
  endtask

  task automatic send(input int p, input int id, input int cnt);
    req_valid[p] = 1'b1;
    req_id[p]    = IW'(id);
    req_cnt[p]   = CW'(cnt);
  endtask

  // Response is due in the cycle after the one in which the request is driven.
  task automatic expect_rsp(input int p, input int id, input int err);
    exp_t e;
    e.port = p;
    e.id   = id;
    e.err  = err;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_valid[p]) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].port == p) idx = i;
          if (idx < 0) begin
            check($sformatf("unexpected_rsp_p%0d", p), 1, 0);
          end else begin
            check($sformatf("rsp_id_p%0d", p), int'(rsp_id[p]), exp_q[idx].id);
            check($sformatf("rsp_err_p%0d", p), int'(rsp_err[p]), exp_q[idx].err);
            check($sformatf("rsp_cycle_p%0d", p), cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
          end
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc < cyc || (exp_q[i].cyc == cyc && !rsp_valid[exp_q[i].port])) begin
          check($sformatf("missing_rsp_p%0d", exp_q[i].port), 0, 1);
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_reqs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready_bits(), 'hF);
    check("reset_valid", valid_bits(), 0);
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("reset_rsp_id_p%0d", p), int'(rsp_id[p]), 0);
      check($sformatf("reset_rsp_err_p%0d", p), int'(rsp_err[p]), 0);
    end
    repeat (10) tick();
    check("idle_ready", ready_bits(), 'hF);
    check("idle_valid", valid_bits(), 0);

    // merged same-cycle arrivals on ID 1
    for (int p = 0; p < NP; p++) begin
      send(p, 1, 1);
      expect_rsp(p, 1, 0);
    end
    tick(); clear_reqs();
    check("merged_ready", ready_bits(), 'hF);
    // ID 1 counter must be back at 0: 3 + 1 releases cleanly
    send(0, 1, 3);
    tick(); clear_reqs();
    check("w3_wait_ready", ready_bits(), 'hE);
    send(1, 1, 1);
    expect_rsp(0, 1, 0);
    expect_rsp(1, 1, 0);
    tick(); clear_reqs();
    check("w3w1_ready", ready_bits(), 'hF);

    // bad ID, then zero weight
    send(0, 3, 1);
    expect_rsp(0, 3, 1);
    tick(); clear_reqs();
    check("bad_id_ready", ready_bits(), 'hF);
    send(1, 0, 0);
    expect_rsp(1, 0, 1);
    tick(); clear_reqs();
    check("hold_valid_p0", int'(rsp_valid[0]), 0);
    check("hold_id_p0", int'(rsp_id[0]), 3);
    check("zero_w_ready", ready_bits(), 'hF);

    // overshoot: 3 + 2 > 4
    send(0, 0, 3);
    tick(); clear_reqs();
    check("over_wait_ready", ready_bits(), 'hE);
    send(1, 0, 2);
    expect_rsp(0, 0, 1);
    expect_rsp(1, 0, 1);
    tick(); clear_reqs();
    check("over_ready", ready_bits(), 'hF);

    // clean 3 + 1 after overshoot
    send(0, 0, 3);
    tick(); clear_reqs();
    send(1, 0, 1);
    expect_rsp(0, 0, 0);
    expect_rsp(1, 0, 0);
    tick(); clear_reqs();
    check("clean_ready", ready_bits(), 'hF);

    // simultaneous releases of two IDs
    send(0, 0, 2); send(1, 0, 2); send(2, 1, 2); send(3, 1, 2);
    expect_rsp(0, 0, 0); expect_rsp(1, 0, 0);
    expect_rsp(2, 1, 0); expect_rsp(3, 1, 0);
    tick(); clear_reqs();
    check("dual_ready", ready_bits(), 'hF);

    // single port with full weight never waits
    send(2, 2, 4);
    expect_rsp(2, 2, 0);
    tick(); clear_reqs();
    check("single_ready", ready_bits(), 'hF);

    // bad request alongside a progressing barrier leaves the counter alone
    send(0, 3, 2);
    send(1, 2, 3);
    expect_rsp(0, 3, 1);
    tick(); clear_reqs();
    check("mix_ready", ready_bits(), 'hD);
    send(2, 2, 1);
    expect_rsp(1, 2, 0);
    expect_rsp(2, 2, 0);
    tick(); clear_reqs();
    check("mix_done_ready", ready_bits(), 'hF);

    // split barrier on ID 2
    send(0, 2, 1); send(1, 2, 1);
    tick(); clear_reqs();
    check("split_c1_ready", ready_bits(), 'hC);
    tick();
    check("split_c2_ready", ready_bits(), 'hC);
    tick();
    check("split_c3_ready", ready_bits(), 'hC);
    send(2, 2, 1); send(3, 2, 1);
    for (int p = 0; p < NP; p++) expect_rsp(p, 2, 0);
    tick(); clear_reqs();
    check("split_c4_ready", ready_bits(), 'hF);
    // back-to-back arrivals in the response cycle
    send(0, 2, 1); send(1, 2, 1);
    tick(); clear_reqs();
    check("b2b_ready", ready_bits(), 'hC);
    tick();
    check("b2b_hold_ready", ready_bits(), 'hC);

    // reset while ports 0,1 wait on ID 2
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready_bits(), 'hF);
    check("midrst_valid", valid_bits(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_ready", ready_bits(), 'hF);
    check("postrst_valid", valid_bits(), 0);

    // fresh barrier on ID 2 needs all four arrivals
    send(0, 2, 1); send(1, 2, 1); send(2, 2, 1);
    tick(); clear_reqs();
    check("fresh_wait_ready", ready_bits(), 'h8);
    send(3, 2, 1);
    for (int p = 0; p < NP; p++) expect_rsp(p, 2, 0);
    tick(); clear_reqs();
    check("fresh_done_ready", ready_bits(), 'hF);

    repeat (3) tick();
    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
